// File: rtl/lcd_char_receiver.sv
// Responder for the memory-mapped character LCD bus: decodes HD44780-style
// commands and data writes into a 32-character display RAM and models busy.
//
// state    | meaning
// ST_CLEAR | filling RAM with CLEAR_FILL, one location per cycle, busy
// ST_IDLE  | ready, accepts bus transactions
// ST_WAIT  | busy for BUSY_CYCLES after an accepted operation
module lcd_char_receiver #(
  parameter int          BUSY_CYCLES = 4,
  parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_data,
  input  logic [1:0] lcd_ctrl,
  input  logic       lcd_enable,
  output logic [7:0] lcd_rdata,
  output logic       busy,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       overrun,
  input  logic [4:0] char_addr,
  output logic [7:0] char_data,
  output logic       char_strobe,
  output logic [7:0] char_value
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int             CW       = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(BUSY_CYCLES - 1);

  localparam logic [1:0] CTRL_CMD    = 2'b00;
  localparam logic [1:0] CTRL_STATUS = 2'b01;
  localparam logic [1:0] CTRL_WRITE  = 2'b10;
  localparam logic [1:0] CTRL_READ   = 2'b11;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic            en_q;
  logic            fe;
  logic [4:0]      cursor_d, cursor_step;
  logic            inc_q, inc_d;
  logic            disp_d;
  logic            ovr_d;
  logic [7:0]      rdata_d;
  logic            strobe_d;
  logic [7:0]      value_d;
  logic            ram_we;
  logic [4:0]      ram_waddr;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram [32];

  assign fe          = en_q & ~lcd_enable;
  assign busy        = (state_q != ST_IDLE);
  assign cursor_step = inc_q ? (cursor + 5'd1) : (cursor - 5'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cursor_d  = cursor;
    inc_d     = inc_q;
    disp_d    = display_on;
    ovr_d     = overrun;
    rdata_d   = lcd_rdata;
    strobe_d  = 1'b0;
    value_d   = char_value;
    ram_we    = 1'b0;
    ram_waddr = cursor;
    ram_wdata = lcd_data;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = CLEAR_FILL;
        if (idx_q == 5'd31) state_d = ST_IDLE;
        else                idx_d   = idx_q + 5'd1;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: ;
    endcase

    // Busy is judged on the pre-edge state, so an fe landing on the last
    // busy cycle is still rejected.
    if (fe) begin
      if (lcd_ctrl == CTRL_STATUS) begin
        rdata_d = {busy, 2'b00, cursor};
      end else if (busy) begin
        ovr_d = 1'b1;
      end else begin
        case (lcd_ctrl)
          CTRL_CMD: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
            casez (lcd_data)
              8'b1???????: cursor_d = lcd_data[4:0];
              8'b01??????,
              8'b001?????,
              8'b0001????: ;
              8'b00001???: disp_d = lcd_data[2];
              8'b000001??: inc_d = lcd_data[1];
              8'b0000001?: cursor_d = 5'd0;
              8'b00000001: begin
                cursor_d = 5'd0;
                inc_d    = 1'b1;
                state_d  = ST_CLEAR;
                idx_d    = 5'd0;
              end
              default: state_d = ST_IDLE;
            endcase
          end
          CTRL_WRITE: begin
            ram_we    = 1'b1;
            ram_waddr = cursor;
            ram_wdata = lcd_data;
            strobe_d  = 1'b1;
            value_d   = lcd_data;
            cursor_d  = cursor_step;
            state_d   = ST_WAIT;
            cnt_d     = CNT_LOAD;
          end
          CTRL_READ: begin
            rdata_d  = ram[cursor];
            cursor_d = cursor_step;
            state_d  = ST_WAIT;
            cnt_d    = CNT_LOAD;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      idx_q       <= 5'd0;
      en_q        <= 1'b0;
      cursor      <= 5'd0;
      inc_q       <= 1'b1;
      display_on  <= 1'b0;
      overrun     <= 1'b0;
      lcd_rdata   <= 8'h00;
      char_data   <= 8'h00;
      char_strobe <= 1'b0;
      char_value  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      en_q        <= lcd_enable;
      cursor      <= cursor_d;
      inc_q       <= inc_d;
      display_on  <= disp_d;
      overrun     <= ovr_d;
      lcd_rdata   <= rdata_d;
      char_data   <= ram[char_addr];
      char_strobe <= strobe_d;
      char_value  <= value_d;
    end
  end

  // RAM contents are not reset directly; the CLEAR sweep after reset fills it.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram[ram_waddr] <= ram_wdata;
  end

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Randomized bench for lcd_char_receiver against a transaction-level model
// that tracks busy as an end-cycle number rather than a state machine.
module tb_lcd_char_receiver;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic [7:0] lcd_rdata;
  logic       busy;
  logic [4:0] cursor;
  logic       display_on;
  logic       overrun;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       char_strobe;
  logic [7:0] char_value;

  lcd_char_receiver #(.BUSY_CYCLES(BC), .CLEAR_FILL(8'h20)) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
    .lcd_enable(lcd_enable), .lcd_rdata(lcd_rdata), .busy(busy),
    .cursor(cursor), .display_on(display_on), .overrun(overrun),
    .char_addr(char_addr), .char_data(char_data),
    .char_strobe(char_strobe), .char_value(char_value)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         busy_end = 0;
  int         clear_start = -100;
  int         strobe_at = -1;
  logic [7:0] mram [32];
  logic       mvalid [32];
  logic [4:0] m_cursor;
  logic       m_inc, m_disp, m_ovr;
  logic [7:0] m_rdata, m_value;
  logic       commit_now = 1'b0;
  logic       hold_addr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [4:0] next_cursor(input logic [4:0] c, input logic inc);
    int v;
    v = (int'(c) + (inc ? 1 : 31)) % 32;
    return v[4:0];
  endfunction

  task automatic model_commit();
    logic       bpre;
    logic [7:0] d;
    logic       accept;
    bpre   = (cyc <= busy_end);
    d      = lcd_data;
    accept = 1'b0;
    if (lcd_ctrl == 2'b01) begin
      m_rdata = {bpre, 2'b00, m_cursor};
    end else if (bpre) begin
      m_ovr = 1'b1;
    end else if (lcd_ctrl == 2'b00) begin
      if (d[7])                 begin m_cursor = d[4:0]; accept = 1'b1; end
      else if (d[6] | d[5] | d[4]) accept = 1'b1;
      else if (d[3])            begin m_disp = d[2]; accept = 1'b1; end
      else if (d[2])            begin m_inc = d[1]; accept = 1'b1; end
      else if (d[1])            begin m_cursor = 5'd0; accept = 1'b1; end
      else if (d[0]) begin
        m_cursor    = 5'd0;
        m_inc       = 1'b1;
        clear_start = cyc;
        busy_end    = cyc + 32;
      end
    end else if (lcd_ctrl == 2'b10) begin
      mram[m_cursor]   = d;
      mvalid[m_cursor] = 1'b1;
      m_value          = d;
      strobe_at        = cyc;
      m_cursor         = next_cursor(m_cursor, m_inc);
      accept           = 1'b1;
    end else begin
      m_rdata  = mram[m_cursor];
      m_cursor = next_cursor(m_cursor, m_inc);
      accept   = 1'b1;
    end
    if (accept) busy_end = cyc + BC;
  endtask

  task automatic step();
    logic [4:0] a;
    logic [7:0] exp_char;
    logic       chk_char;
    logic       r;
    int         k;
    a        = char_addr;
    exp_char = mram[a];
    chk_char = mvalid[a];
    r        = rst;
    @(posedge clk);
    cyc++;
    if (r) begin
      busy_end    = cyc + 32;
      clear_start = cyc;
      m_cursor    = 5'd0;
      m_inc       = 1'b1;
      m_disp      = 1'b0;
      m_ovr       = 1'b0;
      m_rdata     = 8'h00;
      m_value     = 8'h00;
      strobe_at   = -1;
      exp_char    = 8'h00;
      chk_char    = 1'b1;
      commit_now  = 1'b0;
    end else begin
      if (cyc > clear_start && cyc <= clear_start + 32) begin
        k = cyc - clear_start - 1;
        mram[k[4:0]]   = 8'h20;
        mvalid[k[4:0]] = 1'b1;
      end
      if (commit_now) begin
        model_commit();
        commit_now = 1'b0;
      end
    end
    #1;
    chk("busy", busy, cyc < busy_end);
    chk("cursor", cursor, m_cursor);
    chk("display_on", display_on, m_disp);
    chk("overrun", overrun, m_ovr);
    chk("lcd_rdata", lcd_rdata, m_rdata);
    chk("char_strobe", char_strobe, cyc == strobe_at);
    chk("char_value", char_value, m_value);
    if (chk_char) chk("char_data", char_data, exp_char);
    if (!hold_addr) char_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic xfer(input logic [1:0] c, input logic [7:0] d);
    lcd_ctrl   = c;
    lcd_data   = d;
    lcd_enable = 1'b1;
    step();
    lcd_enable = 1'b0;
    commit_now = 1'b1;
    step();
  endtask

  task automatic sweep();
    hold_addr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      char_addr = 5'(i);
      step();
    end
    hold_addr = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [7:0] exp);
    hold_addr = 1'b1;
    char_addr = a;
    step();
    chk(tag, char_data, exp);
    hold_addr = 1'b0;
  endtask

  function automatic logic [7:0] rand_cmd();
    int sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       return 8'h01;
      1:       return 8'h00;
      2, 3:    return 8'($urandom_range(8'h80, 8'hFF));
      4:       return 8'($urandom_range(8'h10, 8'h7F));
      5, 6:    return 8'($urandom_range(8'h08, 8'h0F));
      7, 8:    return 8'($urandom_range(8'h04, 8'h07));
      9:       return 8'($urandom_range(8'h02, 8'h03));
      default: return 8'($urandom_range(8'h80, 8'h9F));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mram[i]   = 8'h00;
      mvalid[i] = 1'b0;
    end
    m_cursor = 5'd0; m_inc = 1'b1; m_disp = 1'b0; m_ovr = 1'b0;
    m_rdata = 8'h00; m_value = 8'h00;
    rst = 1'b1; lcd_enable = 1'b0; lcd_ctrl = 2'b00; lcd_data = 8'h00; char_addr = 5'd0;
    #2;
    idle(2);
    rst = 1'b0;
    idle(31);
    chk("reset_busy_31", busy, 1'b1);
    step();
    chk("reset_busy_done", busy, 1'b0);
    chk("reset_cursor", cursor, 5'd0);
    sweep();

    xfer(2'b00, 8'h85); idle(6);
    xfer(2'b10, 8'h48); idle(6);
    xfer(2'b10, 8'h69); idle(6);
    chk("hi_cursor", cursor, 5'd7);
    peek("hi_ram5", 5'd5, 8'h48);
    peek("hi_ram6", 5'd6, 8'h69);

    xfer(2'b00, 8'h04); idle(6);
    xfer(2'b00, 8'h80); idle(6);
    xfer(2'b10, 8'h41); idle(6);
    chk("dec_cursor", cursor, 5'd31);
    peek("dec_ram0", 5'd0, 8'h41);
    xfer(2'b00, 8'h06); idle(6);
    xfer(2'b10, 8'h5A); idle(6);
    chk("wrap_cursor", cursor, 5'd0);

    xfer(2'b10, 8'h42);
    xfer(2'b10, 8'h43);
    chk("overrun_set", overrun, 1'b1);
    xfer(2'b01, 8'h00);
    chk("status_busy", lcd_rdata, 8'h81);
    idle(6);

    for (int i = 0; i < 32; i++) begin
      xfer(2'b10, 8'($urandom_range(8'h30, 8'h7A)));
      idle(4);
    end
    xfer(2'b00, 8'h01);
    idle(34);
    sweep();
    xfer(2'b00, 8'h01);
    idle(10);
    rst = 1'b1; step(); rst = 1'b0;
    idle(31);
    chk("rst_mid_clear_busy", busy, 1'b1);
    step();
    chk("rst_mid_clear_done", busy, 1'b0);
    sweep();

    xfer(2'b00, 8'h83); idle(5);
    xfer(2'b10, 8'h33); idle(5);
    xfer(2'b00, 8'h83); idle(5);
    xfer(2'b11, 8'h00); idle(5);
    chk("read_rdata", lcd_rdata, 8'h33);
    chk("read_cursor", cursor, 5'd4);
    xfer(2'b00, 8'h0C); idle(5);
    chk("display_on", display_on, 1'b1);
    xfer(2'b00, 8'h00);
    chk("nop_busy", busy, 1'b0);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      if (c == 2'b00) xfer(c, rand_cmd());
      else            xfer(c, 8'($urandom));
      idle($urandom_range(0, 6));
    end
    idle(40);
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
